// File: rtl/fw_pkg.sv
// Shared types for the forwarding/hazard scoreboard.
// One tracked in-flight write per post-decode stage.
package fw_pkg;

    localparam int FW_REG_W = 5;
    localparam int FW_ZERO_REG = 31;
    localparam int unsigned FW_SEL_NONE = '0;

    typedef struct packed {
        logic                valid;
        logic [FW_REG_W-1:0] dest;
        logic                wren;
        logic                load;
    } fw_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fw_match.sv
// Checks one source operand against every in-flight entry.
// Picks the youngest match and flags a load sitting at entry 0.
module fw_match
    import fw_pkg::*;
#(
    parameter  int DEPTH    = 2,
    parameter  int ZERO_REG = FW_ZERO_REG,
    localparam int SELW     = sel_w(DEPTH)
) (
    input  fw_entry_t [DEPTH-1:0]    i_ent,
    input  logic      [FW_REG_W-1:0] i_src,
    input  logic                     i_used,
    output logic      [SELW-1:0]     o_sel,
    output logic                     o_hit0_load
);

    logic [DEPTH-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match[k] = i_ent[k].valid & i_ent[k].wren & i_used
                       & (i_ent[k].dest == i_src)
                       & (i_ent[k].dest != FW_REG_W'(ZERO_REG));
        end
    end

    // Scan oldest to youngest so the youngest match is written last.
    always_comb begin
        o_sel = SELW'(FW_SEL_NONE);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) o_sel = SELW'(k + 1);
        end
    end

    assign o_hit0_load = w_match[0] & i_ent[0].load;

endmodule

// File: rtl/fw_scoreboard.sv
// Forwarding select, load-use stall and stall counter for the pipeline.
// Entry 0 is the instruction one stage ahead of decode.
module fw_scoreboard
    import fw_pkg::*;
#(
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 2,
    parameter  int REG_W    = FW_REG_W,
    parameter  int ZERO_REG = FW_ZERO_REG,
    parameter  int CNT_W    = 16,
    localparam int SELW     = sel_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_dest,
    input  logic                     issue_wren,
    input  logic                     issue_load,
    input  logic                     flush,
    input  logic [NUM_SRC*REG_W-1:0] src_reg,
    input  logic [NUM_SRC-1:0]       src_used,
    output logic [NUM_SRC*SELW-1:0]  fw_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    if (REG_W != FW_REG_W) begin : g_bad_reg_w
        $error("REG_W must equal fw_pkg::FW_REG_W");
    end

    fw_entry_t [DEPTH-1:0] r_ent;
    logic      [CNT_W-1:0] r_cnt;
    logic    [NUM_SRC-1:0] w_hit0_load;
    logic                  w_stall;
    fw_entry_t             w_new;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fw_match #(
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_match (
            .i_ent       (r_ent),
            .i_src       (src_reg[i*REG_W +: REG_W]),
            .i_used      (src_used[i]),
            .o_sel       (fw_sel[i*SELW +: SELW]),
            .o_hit0_load (w_hit0_load[i])
        );
    end

    // Flush dominates: a squashed instruction never needs to wait.
    assign w_stall = issue_valid & ~flush & (|w_hit0_load);

    always_comb begin
        w_new = '0;
        if (issue_valid && !flush && !w_stall) begin
            w_new.valid = 1'b1;
            w_new.dest  = issue_dest;
            w_new.wren  = issue_wren;
            w_new.load  = issue_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ent <= '0;
            r_cnt <= '0;
        end else begin
            r_ent[0] <= w_new;
            for (int k = 1; k < DEPTH; k++) begin
                r_ent[k] <= r_ent[k-1];
            end
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stall     = w_stall;
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fw_scoreboard.sv
// Vector-table and scoreboard bench for fw_scoreboard.
// A second instance with a 2-bit counter covers saturation.
module tb_fw_scoreboard;

    localparam int NS = 2;
    localparam int RW = 5;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             issue_valid;
    logic [RW-1:0]    issue_dest;
    logic             issue_wren;
    logic             issue_load;
    logic             flush;
    logic [NS*RW-1:0] src_reg;
    logic [NS-1:0]    src_used;
    logic [NS*SW-1:0] fw_sel;
    logic [NS*SW-1:0] fw_sel2;
    logic             stall;
    logic             stall2;
    logic [15:0]      cnt;
    logic [1:0]       cnt2;

    fw_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_wren  (issue_wren),
        .issue_load  (issue_load),
        .flush       (flush),
        .src_reg     (src_reg),
        .src_used    (src_used),
        .fw_sel      (fw_sel),
        .stall       (stall),
        .stall_cnt   (cnt)
    );

    fw_scoreboard #(.CNT_W(2)) dut_c2 (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_wren  (issue_wren),
        .issue_load  (issue_load),
        .flush       (flush),
        .src_reg     (src_reg),
        .src_used    (src_used),
        .fw_sel      (fw_sel2),
        .stall       (stall2),
        .stall_cnt   (cnt2)
    );

    typedef struct {
        bit       rst;
        bit       chk;
        bit       v;
        int       d;
        bit       w;
        bit       l;
        bit       f;
        int       s0;
        int       s1;
        int       u;
        int       e0;
        int       e1;
        int       es;
        int       ec;
        string    nm;
    } vec_t;

    typedef struct {
        int    e0;
        int    e1;
        int    es;
        int    ec;
        int    ec2;
        string nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   passes = 0;
    int   total  = 0;

    function automatic vec_t mk(bit rst, bit chk, bit v, int d, bit w,
                                bit l, bit f, int s0, int s1, int u,
                                int e0, int e1, int es, int ec,
                                string nm);
        vec_t r;
        r.rst = rst; r.chk = chk; r.v = v; r.d = d; r.w = w;
        r.l = l; r.f = f; r.s0 = s0; r.s1 = s1; r.u = u;
        r.e0 = e0; r.e1 = e1; r.es = es; r.ec = ec; r.nm = nm;
        return r;
    endfunction

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        reset       = v.rst;
        issue_valid = v.v;
        issue_dest  = RW'(v.d);
        issue_wren  = v.w;
        issue_load  = v.l;
        flush       = v.f;
        src_reg     = {RW'(v.s1), RW'(v.s0)};
        src_used    = NS'(v.u);
        if (v.chk) begin
            e.e0 = v.e0; e.e1 = v.e1; e.es = v.es; e.ec = v.ec;
            e.ec2 = (v.ec > 3) ? 3 : v.ec;
            e.nm = v.nm;
            sbq.push_back(e);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk({e.nm, ".sel0"}, int'(fw_sel[1:0]), e.e0);
        chk({e.nm, ".sel1"}, int'(fw_sel[3:2]), e.e1);
        chk({e.nm, ".stall"}, int'(stall), e.es);
        chk({e.nm, ".cnt"}, int'(cnt), e.ec);
        chk({e.nm, ".cnt2"}, int'(cnt2), e.ec2);
        chk({e.nm, ".stall2"}, int'(stall2), e.es);
    endtask

    task automatic cycle(input vec_t v);
        @(negedge clk);
        drive(v);
        #2;
        if (v.chk) compare();
    endtask

    initial begin
        //           rst chk v  d  w  l  f  s0 s1 u  e0 e1 es ec name
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0"));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst1"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle"));
        tbl.push_back(mk(0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "iss_x5"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0, "fwd_e0"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 5, 2, 0, 2, 0, 0, "fwd_e1"));
        tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "iss_a"));
        tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "iss_b"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0, "youngest"));
        tbl.push_back(mk(0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "ldur_x7"));
        tbl.push_back(mk(0, 1, 1, 8, 1, 0, 0, 7, 0, 1, 1, 0, 1, 0, "lu_stall"));
        tbl.push_back(mk(0, 1, 1, 8, 1, 0, 0, 7, 0, 1, 2, 0, 0, 1, "lu_repres"));
        tbl.push_back(mk(0, 0, 1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "iss_x31"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 31, 0, 1, 0, 0, 0, 1, "zero_reg"));
        tbl.push_back(mk(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "iss_nowr"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0, 1, "wren_mask"));
        tbl.push_back(mk(0, 0, 1, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "ld_x10"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 10, 10, 0, 0, 0, 0, 1, "used_mask"));
        tbl.push_back(mk(0, 0, 1, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "ld_x12"));
        tbl.push_back(mk(0, 1, 1, 13, 1, 0, 1, 12, 0, 1, 1, 0, 0, 1, "flush_lu"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 13, 12, 3, 0, 2, 0, 1, "flush_bub"));
        tbl.push_back(mk(0, 0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "iss_x14"));
        tbl.push_back(mk(0, 0, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "iss_x15"));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 14, 15, 3, 2, 1, 0, 1, "pre_rst"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 14, 15, 3, 0, 0, 0, 0, "post_rst"));

        foreach (tbl[i]) cycle(tbl[i]);

        // Self-dependent loads stall every other cycle; counters saturate.
        cycle(mk(0, 0, 1, 20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "ld_x20"));
        for (int i = 0; i < 10; i++) begin
            int stalls_before;
            stalls_before = (i + 1) / 2;
            cycle(mk(0, 1, 1, 20, 1, 1, 0, 20, 0, 1,
                     (i % 2 == 0) ? 1 : 2, 0, (i % 2 == 0) ? 1 : 0,
                     stalls_before, $sformatf("sat%0d", i)));
        end
        cycle(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, "sat_end"));

        if (sbq.size() != 0) chk("scoreboard_left", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
